bp_be_prio_xbar_reg: RTL and testbench
======================================

// Module: bp_be_prio_xbar_reg
// PURPOSE
//   Priority-select crossbar with a registered output stage for the BE bypass network.
//   Each output port has its own match vector; the block picks one source per output by fixed priority.
//   It forwards that source's data through an AND-OR one-hot crossbar and registers the result for the next stage.
//   Sits between operand match logic and the execute-stage operand flops.
// PARAMETERS
//   els_p      4   number of candidate sources (inputs); must be >= 1
//   o_els_p    2   number of output ports (e.g. rs1, rs2); must be >= 1
//   width_p    64  data width per source/output
//   lo_to_hi_p 1   1: lowest set index wins; 0: highest set index wins
// PORTS
//   clk_i      in   1                  clock, all state on rising edge
//   reset_i    in   1                  asynchronous, active-high reset
//   en_i       in   1                  capture enable; 0 = hold registered outputs (stall)
//   data_i     in   els_p*width_p      source data, element i at [i*width_p +: width_p]
//   match_i    in   o_els_p*els_p      per-output request vector, output j at [j*els_p +: els_p]
//   sel_oh_o   out  o_els_p*els_p      combinational one-hot grant per output (same packing as match_i)
//   data_o     out  o_els_p*width_p    registered selected data per output
//   v_o        out  o_els_p            registered "some source matched" per output
// BEHAVIOUR
//   - Grant, per output j, combinational:
//     - sel_oh_o[j] has exactly one bit set: the lowest-index set bit of match_i[j] (lo_to_hi_p=1),
//       or the highest-index set bit (lo_to_hi_p=0).
//     - All-zero match gives all-zero grant.
//   - Crossbar, combinational: sel_data[j] = OR over i of (data_i[i] & {width_p{sel_oh_o[j][i]}}).
//     - No grant gives sel_data[j] = 0. No X-propagation from unselected sources.
//   - Register stage: on posedge clk_i with en_i=1, data_o[j] <= sel_data[j] and v_o[j] <= |match_i[j].
//     With en_i=0, data_o and v_o hold.
//   - Latency: sel_oh_o is 0 cycles; data_o and v_o are 1 cycle after match_i/data_i are applied.
//   - Reset: reset_i=1 asynchronously forces data_o=0 and v_o=0, at any time including mid-stall.
//     - sel_oh_o is combinational and unaffected by reset.
//     - First capture happens on the first rising edge with reset_i=0 and en_i=1.
//   - Outputs are independent: several outputs may select the same source in the same cycle.
//   - els_p=1: grant = match bit; o_els_p=1: single-output mux. Both must elaborate.
//   - No handshake; the block accepts new inputs every enabled cycle.
// STRUCTURE
//   - No shared package types needed; widths are derived from parameters locally.
//   - One sub-module, bp_be_prio_onehot (width_p, lo_to_hi_p): in [width_p] -> one-hot out [width_p].
//     Generate o_els_p instances, one per output.
//   - The crossbar and output flops are in the top module: a generate loop over outputs, with the AND-OR reduction over sources.
//   - The flop uses an async-reset always block on (posedge clk_i or posedge reset_i).
// TESTING
//   1. Reset: reset_i=1 mid-run -> data_o=0 and v_o=0 immediately (no clock edge needed);
//      after release, hold 0 until the first enabled edge.
//   2. Priority, lo_to_hi_p=1, els_p=4: match_i[0]=4'b1010, data_i={D3,D2,D1,D0}
//      -> sel_oh_o[0]=4'b0010, next cycle data_o[0]=D1, v_o[0]=1.
//   3. Priority, lo_to_hi_p=0: same stimulus -> sel_oh_o[0]=4'b1000, data_o[0]=D3.
//   4. No match: match_i[1]=0 with data_i all 64'hFFFF... -> sel_oh_o[1]=0, next cycle data_o[1]=0, v_o[1]=0.
//   5. Shared source: match_i[0]=match_i[1]=4'b0100, data_i[2]=64'hDEAD_BEEF
//      -> both outputs = 64'hDEAD_BEEF, v_o=2'b11.
//   6. Stall: capture 64'h1, set en_i=0, change inputs for 3 cycles -> data_o stays 64'h1;
//      en_i=1 -> new value captured on the next edge.
//   Also: random match/data vs. reference model each cycle; check sel_oh_o one-hot/zero invariant.

Source files
------------

// File: rtl/bp_be_prio_xbar_reg_pkg.sv
// Shared definitions for the BE bypass priority crossbar.
package bp_be_prio_xbar_reg_pkg;

  // Scan direction used when several sources request the same output.
  typedef enum logic {
    PRIO_HI_TO_LO = 1'b0,
    PRIO_LO_TO_HI = 1'b1
  } prio_dir_e;

  // Maps the integer lo_to_hi_p parameter onto the scan direction.
  function automatic prio_dir_e prio_dir(input int lo_to_hi);
    return (lo_to_hi != 0) ? PRIO_LO_TO_HI : PRIO_HI_TO_LO;
  endfunction

endpackage

// File: rtl/bp_be_prio_onehot.sv
// Fixed-priority picker: keeps only the winning set bit of a request vector.
module bp_be_prio_onehot
  import bp_be_prio_xbar_reg_pkg::*;
#(
  parameter int width_p    = 4,
  parameter int lo_to_hi_p = 1
) (
  input  logic [width_p-1:0] req,
  output logic [width_p-1:0] gnt
);

  localparam prio_dir_e dir_lp = prio_dir(lo_to_hi_p);

  generate
    if (dir_lp == PRIO_LO_TO_HI) begin : g_lo
      // Lowest set index wins: first hit scanning upward blocks the rest.
      always_comb begin
        logic found;
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < width_p; k++) begin
          if (req[k] && !found) begin
            gnt[k] = 1'b1;
            found  = 1'b1;
          end
        end
      end
    end else begin : g_hi
      // Highest set index wins: first hit scanning downward blocks the rest.
      always_comb begin
        logic found;
        gnt   = '0;
        found = 1'b0;
        for (int k = width_p - 1; k >= 0; k--) begin
          if (req[k] && !found) begin
            gnt[k] = 1'b1;
            found  = 1'b1;
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/bp_be_prio_xbar_reg.sv
// Priority-select crossbar with registered outputs for the BE bypass network.
// Each output picks one source by fixed priority, AND-OR muxes its data and
// registers the result for the execute-stage operand flops.
module bp_be_prio_xbar_reg
  import bp_be_prio_xbar_reg_pkg::*;
#(
  parameter int els_p      = 4,
  parameter int o_els_p    = 2,
  parameter int width_p    = 64,
  parameter int lo_to_hi_p = 1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       en_i,
  input  logic [els_p*width_p-1:0]   data_i,
  input  logic [o_els_p*els_p-1:0]   match_i,
  output logic [o_els_p*els_p-1:0]   sel_oh_o,
  output logic [o_els_p*width_p-1:0] data_o,
  output logic [o_els_p-1:0]         v_o
);

  generate
    for (genvar j = 0; j < o_els_p; j++) begin : g_out
      logic [els_p-1:0]   gnt_p0;
      logic [width_p-1:0] sel_data_p0;
      logic               vld_p0;
      logic [width_p-1:0] data_p1;
      logic               vld_p1;

      bp_be_prio_onehot #(
        .width_p    (els_p),
        .lo_to_hi_p (lo_to_hi_p)
      ) u_pick (
        .req (match_i[j*els_p +: els_p]),
        .gnt (gnt_p0)
      );

      assign sel_oh_o[j*els_p +: els_p] = gnt_p0;
      assign vld_p0 = |match_i[j*els_p +: els_p];

      // AND-OR crossbar: unselected sources are masked to zero, so no X leaks in.
      always_comb begin
        sel_data_p0 = '0;
        for (int i = 0; i < els_p; i++) begin
          sel_data_p0 = sel_data_p0 | (data_i[i*width_p +: width_p] & {width_p{gnt_p0[i]}});
        end
      end

      // p0 -> p1 register stage
      // Capture selected data and match-valid when enabled; hold during stall.
      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          data_p1 <= '0;
          vld_p1  <= 1'b0;
        end else if (en_i) begin
          data_p1 <= sel_data_p0;
          vld_p1  <= vld_p0;
        end
      end

      assign data_o[j*width_p +: width_p] = data_p1;
      assign v_o[j] = vld_p1;
    end
  endgenerate

endmodule

// File: tb/tb_bp_be_prio_xbar_reg.sv
// Scoreboard bench for bp_be_prio_xbar_reg: lo-to-hi, hi-to-lo and 1x1 instances.
module tb_bp_be_prio_xbar_reg;

  localparam logic [63:0] D0 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] D1 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] D2 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] D3 = 64'h4444_4444_4444_4444;

  logic         clk = 1'b0;
  logic         reset_i = 1'b1;
  logic         en = 1'b0;
  logic [255:0] data = '0;
  logic [7:0]   match = '0;

  logic [7:0]   sel_lo, sel_hi;
  logic [127:0] dout_lo, dout_hi;
  logic [1:0]   v_lo, v_hi;
  logic [0:0]   sel_min, v_min;
  logic [7:0]   dout_min;

  always #5 clk = ~clk;

  bp_be_prio_xbar_reg #(.els_p(4), .o_els_p(2), .width_p(64), .lo_to_hi_p(1)) dut_lo (
    .clk_i(clk), .reset_i(reset_i), .en_i(en), .data_i(data), .match_i(match),
    .sel_oh_o(sel_lo), .data_o(dout_lo), .v_o(v_lo));

  bp_be_prio_xbar_reg #(.els_p(4), .o_els_p(2), .width_p(64), .lo_to_hi_p(0)) dut_hi (
    .clk_i(clk), .reset_i(reset_i), .en_i(en), .data_i(data), .match_i(match),
    .sel_oh_o(sel_hi), .data_o(dout_hi), .v_o(v_hi));

  bp_be_prio_xbar_reg #(.els_p(1), .o_els_p(1), .width_p(8), .lo_to_hi_p(1)) dut_min (
    .clk_i(clk), .reset_i(reset_i), .en_i(en), .data_i(data[7:0]), .match_i(match[0:0]),
    .sel_oh_o(sel_min), .data_o(dout_min), .v_o(v_min));

  typedef struct {
    logic [127:0] d_lo;
    logic [127:0] d_hi;
    logic [1:0]   v;
    logic [7:0]   d_min;
    logic         v_min;
  } exp_t;

  exp_t sb[$];
  exp_t mdl;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [3:0] grant(input logic [3:0] m, input bit lo);
    logic [3:0] g;
    g = '0;
    if (lo) begin
      for (int i = 0; i < 4; i++) if (m[i] && g == 4'b0) g[i] = 1'b1;
    end else begin
      for (int i = 3; i >= 0; i--) if (m[i] && g == 4'b0) g[i] = 1'b1;
    end
    return g;
  endfunction

  function automatic logic [63:0] pick(input logic [3:0] g, input logic [255:0] d);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (g[i]) r = d[i*64 +: 64];
    return r;
  endfunction

  // One cycle of stimulus: apply inputs at negedge, check grants, push the
  // register state expected after the coming rising edge.
  task automatic step(input logic [7:0] m, input logic [255:0] d, input logic e, input logic r);
    @(negedge clk);
    match = m;
    data  = d;
    en    = e;
    if (!r) begin
      reset_i = 1'b0;
    end else if (!reset_i) begin
      #2;
      reset_i = 1'b1;
      #1;
      chk("async_rst_data_lo", dout_lo, 128'h0);
      chk("async_rst_data_hi", dout_hi, 128'h0);
      chk("async_rst_v", {v_lo, v_hi, v_min}, 5'b0);
    end
    #1;
    for (int j = 0; j < 2; j++) begin
      chk("sel_lo", sel_lo[j*4 +: 4], grant(m[j*4 +: 4], 1'b1));
      chk("sel_hi", sel_hi[j*4 +: 4], grant(m[j*4 +: 4], 1'b0));
      chk("onehot_lo", $countones(sel_lo[j*4 +: 4]), (|m[j*4 +: 4]) ? 1 : 0);
    end
    chk("sel_min", sel_min, m[0]);
    if (reset_i) begin
      mdl.d_lo = '0; mdl.d_hi = '0; mdl.v = '0; mdl.d_min = '0; mdl.v_min = 1'b0;
    end else if (e) begin
      for (int j = 0; j < 2; j++) begin
        mdl.d_lo[j*64 +: 64] = pick(grant(m[j*4 +: 4], 1'b1), d);
        mdl.d_hi[j*64 +: 64] = pick(grant(m[j*4 +: 4], 1'b0), d);
        mdl.v[j] = |m[j*4 +: 4];
      end
      mdl.d_min = m[0] ? d[7:0] : 8'h0;
      mdl.v_min = m[0];
    end
    sb.push_back(mdl);
  endtask

  task automatic after_edge;
    @(posedge clk);
    #2;
  endtask

  // Monitor: after every rising edge compare registered outputs to the oldest expectation.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk("data_lo", dout_lo, x.d_lo);
      chk("data_hi", dout_hi, x.d_hi);
      chk("v_lo", v_lo, x.v);
      chk("v_hi", v_hi, x.v);
      chk("data_min", dout_min, x.d_min);
      chk("v_min", v_min, x.v_min);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [255:0] dv;
    logic [255:0] rd;
    dv = {D3, D2, D1, D0};
    mdl.d_lo = '0; mdl.d_hi = '0; mdl.v = '0; mdl.d_min = '0; mdl.v_min = 1'b0;

    #1;
    chk("reset_data_lo", dout_lo, 128'h0);
    chk("reset_v", {v_lo, v_hi}, 4'b0);

    // Released reset, en=0: outputs stay zero
    step(8'h0A, dv, 1'b0, 1'b0);
    after_edge();
    chk("hold_after_reset", dout_lo, 128'h0);

    // Priority both directions
    step(8'h0A, dv, 1'b1, 1'b0);
    chk("t2_sel_lo", sel_lo[3:0], 4'b0010);
    chk("t3_sel_hi", sel_hi[3:0], 4'b1000);
    after_edge();
    chk("t2_data_lo", dout_lo[63:0], D1);
    chk("t3_data_hi", dout_hi[63:0], D3);
    chk("t2_v0", v_lo[0], 1'b1);

    // No match on output 1
    step(8'h01, {256{1'b1}}, 1'b1, 1'b0);
    chk("t4_sel1", sel_lo[7:4], 4'b0000);
    after_edge();
    chk("t4_data1", dout_lo[127:64], 64'h0);
    chk("t4_v", v_lo, 2'b01);

    // Shared source
    step(8'h44, {D3, 64'hDEAD_BEEF, D1, D0}, 1'b1, 1'b0);
    after_edge();
    chk("t5_data_lo", dout_lo, {2{64'hDEAD_BEEF}});
    chk("t5_data_hi", dout_hi, {2{64'hDEAD_BEEF}});
    chk("t5_v", v_lo, 2'b11);

    // Stall
    step(8'h01, {D3, D2, D1, 64'h1}, 1'b1, 1'b0);
    after_edge();
    chk("t6_capture", dout_lo[63:0], 64'h1);
    step(8'hFF, dv, 1'b0, 1'b0);
    step(8'h22, ~dv, 1'b0, 1'b0);
    step(8'h88, dv ^ {4{64'h5A5A}}, 1'b0, 1'b0);
    after_edge();
    chk("t6_stalled", dout_lo[63:0], 64'h1);
    step(8'h02, dv, 1'b1, 1'b0);
    after_edge();
    chk("t6_resume", dout_lo[63:0], D1);

    // Reset mid-stall and mid-run
    step(8'h01, dv, 1'b0, 1'b0);
    step(8'h11, dv, 1'b1, 1'b1);
    step(8'h11, dv, 1'b1, 1'b1);
    step(8'h11, dv, 1'b0, 1'b0);
    after_edge();
    chk("t1_hold_zero", dout_lo, 128'h0);
    step(8'h11, dv, 1'b1, 1'b0);
    after_edge();
    chk("t1_first_capture", dout_lo, {D0, D0});

    // Random vectors against the model
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 8; k++) rd[k*32 +: 32] = $urandom;
      step(8'($urandom), rd, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
    end
    step(8'h00, '0, 1'b1, 1'b0);

    repeat (2) @(posedge clk);
    #3;
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
